// File: rtl/approx_region_timer.sv
// Measures how long each approximate-branch region stays open, flags budget overruns,
// and queues one completion record per region for the statistics logic.
module approx_region_timer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUDGET_WIDTH = 16,
  parameter int REC_DEPTH    = 4,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   beginCycle,
  input  logic [DATA_WIDTH-1:0]   cycleCounter,
  input  logic                    regionEnd,
  input  logic                    flush,
  input  logic [BUDGET_WIDTH-1:0] budget,
  output logic                    active,
  output logic [BUDGET_WIDTH-1:0] elapsed,
  output logic                    expired,
  output logic                    recValid,
  input  logic                    recReady,
  output logic [BUDGET_WIDTH-1:0] recCycles,
  output logic                    recTimedOut,
  output logic [DROP_WIDTH-1:0]   dropCount
);

  localparam int PTR_W = (REC_DEPTH > 1) ? $clog2(REC_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(REC_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t state_q;

  // ---------------------------------------------------------------------------
  // Elapsed measurement (modular subtraction handles counter wrap)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   raw_diff;
  logic [BUDGET_WIDTH-1:0] elapsed_sat;
  logic                    is_open;

  assign raw_diff = cycleCounter - beginCycle;
  assign is_open  = (state_q != S_IDLE);

  generate
    if (DATA_WIDTH > BUDGET_WIDTH) begin : g_sat
      logic raw_overflow;
      assign raw_overflow = |raw_diff[DATA_WIDTH-1:BUDGET_WIDTH];
      assign elapsed_sat  = raw_overflow ? {BUDGET_WIDTH{1'b1}} : raw_diff[BUDGET_WIDTH-1:0];
    end else begin : g_nosat
      assign elapsed_sat = BUDGET_WIDTH'(raw_diff);
    end
  endgenerate

  assign elapsed = is_open ? elapsed_sat : '0;
  assign active  = is_open;

  // ---------------------------------------------------------------------------
  // Region events
  // ---------------------------------------------------------------------------
  logic close_evt;
  logic expire_evt;

  // Any open region closes on regionEnd or on a re-open; flush discards it silently.
  assign close_evt  = is_open && !flush && (regionEnd || start);
  assign expire_evt = (state_q == S_RUNNING) && !flush && !regionEnd && !start &&
                      (budget != '0) && (elapsed_sat >= budget);
  assign expired    = expire_evt;

  // ---------------------------------------------------------------------------
  // Region FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!flush && start) begin
            state_q <= S_RUNNING;
          end
        end
        S_RUNNING, S_EXPIRED: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (regionEnd) begin
            state_q <= start ? S_RUNNING : S_IDLE;
          end else if (start) begin
            state_q <= S_RUNNING;
          end else if (expire_evt) begin
            state_q <= S_EXPIRED;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Completion-record FIFO
  // ---------------------------------------------------------------------------
  logic [BUDGET_WIDTH-1:0] mem_cycles_q [REC_DEPTH];
  logic                    mem_to_q     [REC_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DROP_WIDTH-1:0]   drop_q, drop_d;
  logic                    fifo_full;
  logic                    pop;
  logic                    push_acc;
  logic                    push_drop;

  assign fifo_full = (count_q == FULL_CNT);
  assign recValid  = (count_q != '0);
  assign pop       = recValid && recReady;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push_acc  = close_evt && (!fifo_full || pop);
  assign push_drop = close_evt && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_drop && (drop_q != {DROP_WIDTH{1'b1}})) begin
      drop_d = drop_q + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REC_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_acc && (wr_ptr_q == PTR_W'(gi))) begin
          mem_cycles_q[gi] <= elapsed_sat;
          mem_to_q[gi]     <= (state_q == S_EXPIRED);
        end
      end
    end
  endgenerate

  // Head fields read as zero when empty so stale entries never leak after reset.
  assign recCycles   = recValid ? mem_cycles_q[rd_ptr_q] : '0;
  assign recTimedOut = recValid ? mem_to_q[rd_ptr_q] : 1'b0;
  assign dropCount   = drop_q;

endmodule

// File: tb/tb_approx_region_timer.sv
// Directed bench for approx_region_timer: spec-level model checked every cycle
// plus literal expectations for each test scenario.
module tb_approx_region_timer;

  localparam int DW  = 32;
  localparam int BW  = 16;
  localparam int RD  = 4;
  localparam int DRW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] beginCycle;
  logic [DW-1:0] cycleCounter;
  logic          regionEnd;
  logic          flush;
  logic [BW-1:0] budget;
  logic          active;
  logic [BW-1:0] elapsed;
  logic          expired;
  logic          recValid;
  logic          recReady;
  logic [BW-1:0] recCycles;
  logic          recTimedOut;
  logic [DRW-1:0] dropCount;

  always #5 clk = ~clk;

  approx_region_timer #(
    .DATA_WIDTH(DW), .BUDGET_WIDTH(BW), .REC_DEPTH(RD), .DROP_WIDTH(DRW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .beginCycle(beginCycle),
    .cycleCounter(cycleCounter), .regionEnd(regionEnd), .flush(flush),
    .budget(budget), .active(active), .elapsed(elapsed), .expired(expired),
    .recValid(recValid), .recReady(recReady), .recCycles(recCycles),
    .recTimedOut(recTimedOut), .dropCount(dropCount)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Spec-level model: region open flag, timed-out flag, record queue, drop count.
  typedef struct packed {
    logic [BW-1:0] cyc;
    logic          to;
  } rec_t;

  bit            m_open = 1'b0;
  bit            m_tout = 1'b0;
  rec_t          m_q[$];
  int            m_drops = 0;
  logic [DW-1:0] e_raw;
  logic [BW-1:0] e_el;
  bit            e_ex, m_pop, m_push, m_full;
  int            pulse_cnt = 0;
  logic [DW-1:0] pulse_cc = '0;

  always @(negedge clk) begin
    e_raw = cycleCounter - beginCycle;
    if (!m_open)               e_el = '0;
    else if (e_raw > 32'hFFFF) e_el = 16'hFFFF;
    else                       e_el = e_raw[BW-1:0];
    e_ex = m_open && !m_tout && !flush && !regionEnd && !start &&
           (budget != 0) && (e_el >= budget);
    if (checking) begin
      chk("active", active, m_open);
      chk("elapsed", elapsed, e_el);
      chk("expired", expired, e_ex);
      chk("recValid", recValid, m_q.size() > 0);
      chk("recCycles", recCycles, (m_q.size() > 0) ? m_q[0].cyc : 16'd0);
      chk("recTimedOut", recTimedOut, (m_q.size() > 0) ? m_q[0].to : 1'b0);
      chk("dropCount", dropCount, m_drops);
      if (expired === 1'b1) begin
        pulse_cnt++;
        pulse_cc = cycleCounter;
      end
    end
    if (rst) begin
      m_open = 0; m_tout = 0; m_q.delete(); m_drops = 0;
    end else begin
      m_full = (m_q.size() == RD);
      m_pop  = (m_q.size() > 0) && recReady;
      m_push = m_open && !flush && (regionEnd || start);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_full && !m_pop) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          m_q.push_back({e_el, m_tout});
        end
      end
      if (flush) m_open = 0;
      else if (m_open && regionEnd) begin m_open = start; m_tout = 0; end
      else if (start) begin m_open = 1; m_tout = 0; end
      else if (e_ex) m_tout = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic open_region(input logic [DW-1:0] bc);
    cycleCounter = bc - 1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    beginCycle = bc;
    cycleCounter = bc;
  endtask

  task automatic run_until(input logic [DW-1:0] target);
    while (cycleCounter != target) begin
      cyc();
      cycleCounter = cycleCounter + 1;
    end
  endtask

  task automatic close_region();
    regionEnd = 1'b1;
    cyc();
    regionEnd = 1'b0;
    cycleCounter = cycleCounter + 1;
  endtask

  task automatic pop1();
    recReady = 1'b1;
    cyc();
    recReady = 1'b0;
  endtask

  int exp_order[4] = '{2, 3, 4, 7};

  initial begin
    rst = 1; start = 0; regionEnd = 0; flush = 0; recReady = 0;
    beginCycle = '0; cycleCounter = '0; budget = '0;
    cyc(); cyc();
    rst = 0;
    checking = 1;
    @(negedge clk);
    chk("reset_active", active, 0);
    chk("reset_recValid", recValid, 0);
    chk("reset_dropCount", dropCount, 0);

    // Basic region
    budget = 0;
    open_region(100);
    @(negedge clk);
    chk("t1_active_open", active, 1);
    run_until(130);
    close_region();
    @(negedge clk);
    chk("t1_recValid", recValid, 1);
    chk("t1_recCycles", recCycles, 30);
    chk("t1_recTimedOut", recTimedOut, 0);
    chk("t1_active_closed", active, 0);
    chk("t1_no_pulse", pulse_cnt, 0);
    pop1();

    // Expiry
    pulse_cnt = 0;
    budget = 8;
    open_region(200);
    run_until(215);
    close_region();
    @(negedge clk);
    chk("t2_pulse_count", pulse_cnt, 1);
    chk("t2_pulse_cc", pulse_cc, 208);
    chk("t2_recCycles", recCycles, 15);
    chk("t2_recTimedOut", recTimedOut, 1);
    chk("t2_idle", active, 0);
    pop1();

    // Wrap and saturate
    budget = 0;
    open_region(32'hFFFF_FFF0);
    run_until(32'h10);
    close_region();
    @(negedge clk);
    chk("t3_wrap", recCycles, 32);
    pop1();
    open_region(0);
    cycleCounter = 32'h2_0000;
    @(negedge clk);
    chk("t3_elapsed_sat", elapsed, 16'hFFFF);
    close_region();
    @(negedge clk);
    chk("t3_sat_rec", recCycles, 16'hFFFF);
    chk("t3_sat_to", recTimedOut, 0);
    pop1();

    // Flush and restart
    open_region(50);
    run_until(55);
    flush = 1;
    cyc();
    flush = 0;
    @(negedge clk);
    chk("t4_flush_idle", active, 0);
    chk("t4_flush_norec", recValid, 0);
    open_region(300);
    run_until(310);
    regionEnd = 1; start = 1;
    cyc();
    regionEnd = 0; start = 0;
    beginCycle = 310;
    cycleCounter = 311;
    @(negedge clk);
    chk("t4_reopen_rec", recCycles, 10);
    chk("t4_reopen_active", active, 1);
    chk("t4_reopen_elapsed", elapsed, 1);
    run_until(325);
    close_region();
    @(negedge clk);
    chk("t4_head_first", recCycles, 10);
    pop1();
    @(negedge clk);
    chk("t4_head_second", recCycles, 15);
    pop1();

    // FIFO backpressure
    recReady = 0;
    for (int k = 1; k <= 6; k++) begin
      open_region(1000);
      run_until(1000 + k);
      close_region();
    end
    @(negedge clk);
    chk("t5_drops", dropCount, 2);
    chk("t5_head", recCycles, 1);
    open_region(1000);
    run_until(1007);
    recReady = 1; regionEnd = 1;
    cyc();
    recReady = 0; regionEnd = 0;
    @(negedge clk);
    chk("t5_pushpop_head", recCycles, 2);
    chk("t5_pushpop_drops", dropCount, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_order", recCycles, exp_order[i]);
      pop1();
    end
    @(negedge clk);
    chk("t5_drained", recValid, 0);

    // Reset mid-operation
    budget = 4;
    for (int k = 1; k <= 3; k++) begin
      open_region(2000);
      run_until(2000 + k);
      close_region();
    end
    open_region(2000);
    run_until(2006);
    @(negedge clk);
    chk("t6_expired_state_active", active, 1);
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t6_active", active, 0);
    chk("t6_elapsed", elapsed, 0);
    chk("t6_expired", expired, 0);
    chk("t6_recValid", recValid, 0);
    chk("t6_recCycles", recCycles, 0);
    chk("t6_recTimedOut", recTimedOut, 0);
    chk("t6_dropCount", dropCount, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_region_timer.md
Name: approx_region_timer

Overview:
- Downstream consumer of the begin-cycle register in the fetch unit.
- Takes the latched begin cycle and the free-running cycle counter, and measures how long each approximate-branch region stays open.
- Flags a region that exceeds a programmable cycle budget.
- Pushes one completion record per region into a small FIFO drained by the performance/statistics logic over a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, width of the cycle counter and begin-cycle value
BUDGET_WIDTH, 16, width of the budget, elapsed and record-cycle fields
REC_DEPTH, 4, completion-record FIFO depth (power of two, >=2)
DROP_WIDTH, 16, width of the dropped-record counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  same-cycle copy of the begin-cycle register's write-enable (region opens)
beginCycle  in  DATA_WIDTH  begin-cycle register output; valid from the cycle after start
cycleCounter  in  DATA_WIDTH  free-running cycle counter
regionEnd  in  1  approximate region closed (end branch committed)
flush  in  1  pipeline flush; aborts the open region
budget  in  BUDGET_WIDTH  cycle budget; 0 disables expiry
active  out  1  region open (RUNNING or EXPIRED)
elapsed  out  BUDGET_WIDTH  current saturated elapsed cycles; 0 when IDLE
expired  out  1  one-cycle pulse on the RUNNING->EXPIRED transition
recValid  out  1  FIFO head valid
recReady  in  1  consumer accepts head
recCycles  out  BUDGET_WIDTH  head record: saturated elapsed at close
recTimedOut  out  1  head record: region had expired before close
dropCount  out  DROP_WIDTH  records dropped because the FIFO was full (saturating)

Behaviour:
- Clock and reset: single clock. All state updates on the rising edge of clk. rst is synchronous and active-high.
- Reset values: state=IDLE, FIFO empty, active=0, elapsed=0, expired=0, recValid=0, recCycles=0, recTimedOut=0, dropCount=0.
- Reset mid-region: discards the measurement and all FIFO contents; no record is produced.
- Elapsed arithmetic:
  - raw = (cycleCounter - beginCycle) mod 2^DATA_WIDTH, so counter wrap-around is handled.
  - elapsed = min(raw, 2^BUDGET_WIDTH-1).
  - elapsed is combinational from registered state and inputs; it is forced to 0 in IDLE.
- FSM states: IDLE, RUNNING, EXPIRED. Priority order per cycle: flush > regionEnd > start > expiry check.
  - IDLE: start -> RUNNING. regionEnd alone is ignored.
  - RUNNING: entered the cycle after start, which is when beginCycle becomes valid.
    - flush -> IDLE, no record.
    - regionEnd -> push {elapsed, 0}; go to RUNNING if start is also asserted, else IDLE.
    - start alone (re-open) -> push {elapsed, 0}, stay RUNNING; the new begin cycle is visible next cycle.
    - Otherwise, budget!=0 && elapsed>=budget -> EXPIRED, expired=1 for exactly this cycle.
  - EXPIRED: same as RUNNING, but pushed records carry timedOut=1 and no further expiry pulse is raised.
- The expiry check is not performed in the start cycle (beginCycle is stale then).
- A budget change mid-region takes effect on the next comparison. Lowering the budget while EXPIRED has no effect.
- FIFO:
  - REC_DEPTH entries, pointer plus count implementation.
  - Pop when recValid && recReady. recValid=1 iff count>0; the head is stable while recValid && !recReady.
  - Push when full and no pop: record dropped, dropCount+1, saturating at all-ones.
  - Push and pop in the same cycle when full: push accepted, count unchanged.
  - Push and pop in the same cycle when empty: the record enters the FIFO and appears at the head next cycle (no bypass).
  - Push-to-recValid latency: 1 cycle.
- flush does not affect FIFO contents.

Test Plan:
- Basic region: rst, then start@t with beginCycle=100 visible @t+1, regionEnd when cycleCounter=130, budget=0 -> record {30, 0} with recValid the next cycle, expired never pulses, active 1 from t+1 until the close.
- Expiry: budget=8, beginCycle=200 -> expired pulses for exactly one cycle when cycleCounter=208; regionEnd at 215 -> record {15, 1}; state returns to IDLE.
- Wrap and saturate:
  - beginCycle=0xFFFF_FFF0, regionEnd at cycleCounter=0x10 -> record {32, 0}.
  - beginCycle=0, regionEnd at 0x2_0000 -> record {0xFFFF, 0}.
- Flush and restart:
  - flush while RUNNING -> no record, state IDLE.
  - regionEnd and start in the same cycle -> one record pushed, next region measures from the new beginCycle.
- FIFO backpressure: recReady=0, close 6 regions with REC_DEPTH=4 -> 4 records held in order, dropCount=2. Then assert recReady together with a push -> count stays 4 and order is preserved.
- Reset mid-operation: rst while EXPIRED with 3 records queued -> next cycle all outputs are at reset values and dropCount=0.
